// File: rtl/spi_regfile_pkg.sv
// spi_regfile_pkg: shared FSM state type and frame length helper for the SPI register file
package spi_regfile_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, OVERRUN} state_t;
  function automatic int frame_bits(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer with rise/fall pulses, edges suppressed until post-reset history is real
module spi_sync_edge #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [2:0] s_q, s_d, v_q, v_d;
  always_comb begin
    s_d = {s_q[1:0], d};
    v_d = {v_q[1:0], 1'b1};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= {3{INIT}};
      v_q <= '0;
    end else begin
      s_q <= s_d;
      v_q <= v_d;
    end
  end
  assign rise = v_q[2] & s_q[1] & ~s_q[2];
  assign fall = v_q[2] & ~s_q[1] & s_q[2];
endmodule

// File: rtl/spi_regfile_ctrl.sv
// spi_regfile_ctrl: SPI mode-0 peripheral giving read/write access to a flat register file
module spi_regfile_ctrl
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);
  localparam int FB = frame_bits(ADDR_W, DATA_W);
  localparam int CW = $clog2(FB + 1);
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_s, addr_ok;
  logic [1:0] copi_q, copi_d;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FB-1:0] sin_q, sin_d, shifted;
  logic [DATA_W-1:0] sout_q, sout_d, cap_data, fr_data;
  logic [ADDR_W-1:0] fr_addr, cap_addr, wr_addr_q, wr_addr_d;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic rd_q, rd_d, cipo_q, cipo_d, oe_q, oe_d, wr_strobe_q, wr_strobe_d, frame_err_q, frame_err_d;
  spi_sync_edge #(.INIT(1'b0)) u_sclk (.clk(clk), .rst(rst), .d(sclk), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.INIT(1'b1)) u_ncs  (.clk(clk), .rst(rst), .d(ncs),  .rise(ncs_rise),  .fall(ncs_fall));
  assign copi_s   = copi_q[1];
  assign shifted  = {sin_q[FB-2:0], copi_s};
  assign fr_addr  = sin_q[DATA_W +: ADDR_W];
  assign fr_data  = sin_q[DATA_W-1:0];
  assign addr_ok  = int'(fr_addr) < NUM_REGS;
  assign cap_addr = shifted[ADDR_W-1:0];
  always_comb begin
    copi_d      = {copi_q[0], copi};
    state_d     = state_q;
    cnt_d       = cnt_q;
    sin_d       = sin_q;
    sout_d      = sout_q;
    rd_d        = rd_q;
    cipo_d      = cipo_q;
    oe_d        = oe_q;
    regs_d      = regs_q;
    wr_addr_d   = wr_addr_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    cap_data    = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (int'(cap_addr) == k) cap_data = regs_q[k*DATA_W +: DATA_W];
    if (ncs_rise && state_q != IDLE) begin
      state_d = IDLE;
      cipo_d  = 1'b0;
      oe_d    = 1'b0;
      if (state_q == DATA && cnt_q == CW'(FB) && addr_ok) begin
        if (sin_q[FB-1]) begin
          for (int k = 0; k < NUM_REGS; k++)
            if (int'(fr_addr) == k) regs_d[k*DATA_W +: DATA_W] = fr_data;
          wr_addr_d   = fr_addr;
          wr_strobe_d = 1'b1;
        end
      end else frame_err_d = 1'b1;
    end else if (state_q == IDLE) begin
      if (ncs_fall) begin
        state_d = ADDR;
        cnt_d   = '0;
        rd_d    = 1'b0;
      end
    end else begin
      if (sclk_rise) begin
        if (state_q == OVERRUN || cnt_q == CW'(FB)) state_d = OVERRUN;
        else begin
          sin_d = shifted;
          cnt_d = cnt_q + CW'(1);
          if (state_q == ADDR && cnt_q == CW'(ADDR_W)) begin
            state_d = DATA;
            sout_d  = cap_data;
            rd_d    = ~shifted[ADDR_W];
          end
        end
      end
      if (sclk_fall && rd_q) begin
        cipo_d = sout_q[DATA_W-1];
        sout_d = sout_q << 1;
        oe_d   = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      copi_q      <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      sin_q       <= '0;
      sout_q      <= '0;
      rd_q        <= 1'b0;
      cipo_q      <= 1'b0;
      oe_q        <= 1'b0;
      regs_q      <= '0;
      wr_addr_q   <= '0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      copi_q      <= copi_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sin_q       <= sin_d;
      sout_q      <= sout_d;
      rd_q        <= rd_d;
      cipo_q      <= cipo_d;
      oe_q        <= oe_d;
      regs_q      <= regs_d;
      wr_addr_q   <= wr_addr_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign cipo      = cipo_q;
  assign cipo_oe   = oe_q;
  assign regs      = regs_q;
  assign wr_addr   = wr_addr_q;
  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;
endmodule
